// File: rtl/toggle_pulse_sequencer.sv
// toggle_pulse_sequencer: drives a TFF bank with counted, gapped T/E pulses.
// Commands arrive over valid/ready; busy/done let a controller chain them.
module toggle_pulse_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8,
    parameter int GAPW  = 4
) (
    input  logic             _clock,
    input  logic             _reset,
    input  logic             _cmd_valid,
    output logic             _cmd_ready,
    input  logic [WIDTH-1:0] _cmd_mask,
    input  logic [CNTW-1:0]  _cmd_count,
    input  logic [GAPW-1:0]  _cmd_gap,
    input  logic             _abort,
    output logic [WIDTH-1:0] _T,
    output logic [WIDTH-1:0] _E,
    output logic             _busy,
    output logic             _done,
    output logic             _return
);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CNTW-1:0]  rem_q, rem_d;
    logic [GAPW-1:0]  gap_q, gap_d;
    logic [GAPW-1:0]  gcnt_q, gcnt_d;
    logic [WIDTH-1:0] t_q, e_q;
    logic             busy_q, done_q;
    logic             accept;

    assign _cmd_ready = (state_q == IDLE) & ~_abort;
    assign accept     = _cmd_valid & _cmd_ready;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    mask_d  = _cmd_mask;
                    rem_d   = _cmd_count;
                    gap_d   = _cmd_gap;
                    gcnt_d  = '0;
                    state_d = (_cmd_count == '0) ? DONE : PULSE;
                end
            end
            PULSE: begin
                if (rem_q != '0) begin
                    rem_d = rem_q - CNTW'(1);
                end
                // rem_q <= 1 means this pulse is the last one
                if (rem_q <= CNTW'(1)) begin
                    state_d = DONE;
                end else if (gap_q == '0) begin
                    state_d = PULSE;
                end else begin
                    state_d = GAP;
                    gcnt_d  = gap_q;
                end
            end
            GAP: begin
                if (gcnt_q <= GAPW'(1)) begin
                    gcnt_d  = '0;
                    state_d = PULSE;
                end else begin
                    gcnt_d = gcnt_q - GAPW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (_abort && state_q != IDLE) begin
            state_d = IDLE;
            rem_d   = '0;
            gcnt_d  = '0;
        end
    end

    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            rem_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            t_q     <= '0;
            e_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            t_q     <= (state_d == PULSE) ? mask_d : '0;
            e_q     <= (state_d == PULSE) ? mask_d : '0;
            busy_q  <= (state_d == PULSE) || (state_d == GAP);
            done_q  <= (state_d == DONE);
        end
    end

    assign _T      = t_q;
    assign _E      = e_q;
    assign _busy   = busy_q;
    assign _done   = done_q;
    assign _return = busy_q;

endmodule

// File: tb/tb_toggle_pulse_sequencer.sv
// tb_toggle_pulse_sequencer: directed vectors plus multi-cycle sequences.
// Includes a behavioural TFF bank fed by _T/_E.
module tb_toggle_pulse_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] mask = '0;
    logic [7:0] cnt = '0;
    logic [3:0] gap = '0;
    logic       ready, busy, done, ret;
    logic [7:0] t, e;
    logic [7:0] tff;
    int         checks = 0;
    int         errors = 0;

    toggle_pulse_sequencer #(.WIDTH(8), .CNTW(8), .GAPW(4)) dut (
        ._clock(clk),
        ._reset(rst),
        ._cmd_valid(valid),
        ._cmd_ready(ready),
        ._cmd_mask(mask),
        ._cmd_count(cnt),
        ._cmd_gap(gap),
        ._abort(abort),
        ._T(t),
        ._E(e),
        ._busy(busy),
        ._done(done),
        ._return(ret)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) tff <= '0;
        else tff <= tff ^ (t & e);
    end

    typedef struct {
        logic       v;
        logic [7:0] m;
        logic [7:0] c;
        logic [3:0] g;
        logic       a;
        logic       rdy;
        logic [7:0] et;
        logic       b;
        logic       d;
        logic [7:0] q;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] m,
                         input logic [7:0] c, input logic [3:0] g,
                         input logic a);
        valid = v;
        mask  = m;
        cnt   = c;
        gap   = g;
        abort = a;
    endtask

    initial begin
        logic [7:0] exp_t[5];
        logic       exp_r[5];
        logic       exp_d[5];
        int         pulses;
        int         done_at;
        logic       saw_done;
        logic       saw_t;

        // v  mask   cnt   gap   ab | rdy  T      busy done tffQ
        tbl[0] = '{1'b1, 8'hA5, 8'd3, 4'd0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 8'h00, 8'd0, 4'd0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5};
        tbl[2] = '{1'b0, 8'h00, 8'd0, 4'd0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 8'h00};
        tbl[3] = '{1'b0, 8'h00, 8'd0, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5};
        tbl[4] = '{1'b0, 8'h00, 8'd0, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5};
        tbl[5] = '{1'b1, 8'hFF, 8'd0, 4'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA5};
        tbl[6] = '{1'b0, 8'h00, 8'd0, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5};
        tbl[7] = '{1'b1, 8'h3C, 8'd2, 4'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5};
        tbl[8] = '{1'b0, 8'h00, 8'd0, 4'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5};

        // reset state
        #12;
        chk("rst_T", t, 8'h00);
        chk("rst_E", e, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // back-to-back, zero count, abort in IDLE
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].v, tbl[i].m, tbl[i].c, tbl[i].g, tbl[i].a);
            #1;
            chk($sformatf("tbl%0d_ready", i), ready, tbl[i].rdy);
            step();
            chk($sformatf("tbl%0d_T", i), t, tbl[i].et);
            chk($sformatf("tbl%0d_E", i), e, tbl[i].et);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].b);
            chk($sformatf("tbl%0d_ret", i), ret, tbl[i].b);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].d);
            chk($sformatf("tbl%0d_tff", i), tff, tbl[i].q);
        end

        // gapped pulses: count=4, gap=3
        drive(1'b1, 8'h0F, 8'd4, 4'd3, 1'b0);
        step();
        drive(1'b0, 8'h00, 8'd0, 4'd0, 1'b0);
        for (int c = 0; c < 14; c++) begin
            chk($sformatf("gap_T%0d", c), t,
                ((c % 4 == 0) && c <= 12) ? 8'h0F : 8'h00);
            chk($sformatf("gap_busy%0d", c), busy, c <= 12);
            chk($sformatf("gap_done%0d", c), done, c == 13);
            step();
        end
        chk("gap_ready14", ready, 1'b1);

        // abort at third pulse: count=10, gap=1
        drive(1'b1, 8'h3C, 8'd10, 4'd1, 1'b0);
        step();
        drive(1'b0, 8'h00, 8'd0, 4'd0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("ab_T%0d", c), t, (c % 2 == 0) ? 8'h3C : 8'h00);
            step();
        end
        chk("ab_T4", t, 8'h3C);
        abort = 1'b1;
        step();
        chk("ab_T_after", t, 8'h00);
        chk("ab_busy_after", busy, 1'b0);
        chk("ab_done_after", done, 1'b0);
        chk("ab_ready_held", ready, 1'b0);
        step();
        chk("ab_ready_held2", ready, 1'b0);
        abort = 1'b0;
        #1;
        chk("ab_ready_rel", ready, 1'b1);
        saw_done = 1'b0;
        saw_t = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (done) saw_done = 1'b1;
            if (t != 0) saw_t = 1'b1;
        end
        chk("ab_no_done", saw_done, 1'b0);
        chk("ab_no_pulse", saw_t, 1'b0);

        // reset during second GAP: count=5, gap=2
        drive(1'b1, 8'hFF, 8'd5, 4'd2, 1'b0);
        step();
        drive(1'b0, 8'h00, 8'd0, 4'd0, 1'b0);
        for (int c = 0; c < 4; c++) step();
        chk("rm_busy_pre", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rm_T", t, 8'h00);
        chk("rm_E", e, 8'h00);
        chk("rm_busy", busy, 1'b0);
        chk("rm_done", done, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rm_ready", ready, 1'b1);
        saw_done = 1'b0;
        saw_t = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (done) saw_done = 1'b1;
            if (t != 0) saw_t = 1'b1;
        end
        chk("rm_no_done", saw_done, 1'b0);
        chk("rm_no_pulse", saw_t, 1'b0);

        // handshake hold-off with changed inputs
        exp_t = '{8'h11, 8'h00, 8'h11, 8'h00, 8'h00};
        exp_r = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_d = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        drive(1'b1, 8'h11, 8'd2, 4'd1, 1'b0);
        #1;
        chk("ho_ready0", ready, 1'b1);
        step();
        drive(1'b1, 8'h22, 8'd1, 4'd0, 1'b0);
        for (int r = 0; r < 5; r++) begin
            #1;
            chk($sformatf("ho_ready%0d", r), ready, exp_r[r]);
            chk($sformatf("ho_T%0d", r), t, exp_t[r]);
            chk($sformatf("ho_done%0d", r), done, exp_d[r]);
            step();
        end
        drive(1'b0, 8'h00, 8'd0, 4'd0, 1'b0);
        chk("ho_T_new", t, 8'h22);
        chk("ho_busy_new", busy, 1'b1);
        step();
        chk("ho_done_new", done, 1'b1);
        step();

        // maximum count, back-to-back
        drive(1'b1, 8'h01, 8'd255, 4'd0, 1'b0);
        step();
        drive(1'b0, 8'h00, 8'd0, 4'd0, 1'b0);
        pulses = 0;
        done_at = -1;
        for (int c = 0; c < 300; c++) begin
            if (t == 8'h01) pulses++;
            if (done && done_at < 0) done_at = c;
            step();
        end
        chk("max_pulses", pulses, 255);
        chk("max_done_at", done_at, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
